ultrasonic_detect: RTL
======================

Name: ultrasonic_detect

Overview:
Front-end stage for the door presence path. It periodically fires an ultrasonic ranger (HC-SR04 class) trigger, measures the echo pulse width in clk cycles, and compares it against a distance threshold. When an object is nearer than the threshold, it emits a single-cycle detect pulse. That pulse drives the downstream pulse stretcher input (measurein), which holds the door signal for ~51 ms.

Parameters:
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz).
PERIOD_CYCLES, 3000000, cycles from one trigger start to the next (60 ms).
ECHO_TIMEOUT, 1900000, maximum cycles waited for an echo rise, and maximum echo width (38 ms).
THRESH_CYCLES, 145000, detect when echo width < this value (~50 cm).
CW, 22, counter/width bit width; must hold PERIOD_CYCLES.

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = run measurement cycles; sampled only in IDLE and at the end of HOLDOFF
echo  input  1  raw sensor echo; asynchronous to clk
trig  output  1  sensor trigger
detect  output  1  one-cycle pulse: object within threshold
echo_width  output  CW  last completed echo width in cycles; saturates at ECHO_TIMEOUT
width_valid  output  1  one-cycle pulse when echo_width updates
timeout  output  1  one-cycle pulse: no echo rise, or echo stuck high
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset values: all outputs 0; echo_width 0; state IDLE; all counters 0. Asserting reset mid-cycle drops trig immediately (async) and abandons the measurement with no pulses.
- echo passes through a 2-FF synchronizer to echo_s. The rise/fall edge detector compares echo_s with its 1-cycle delayed copy.
- pcnt: period counter. Cleared on entry to TRIG, then +1 per cycle, saturating at PERIOD_CYCLES-1.
- IDLE: trig=0. If enable=1, go to TRIG next cycle.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles, then WAIT_RISE with wcnt cleared.
- WAIT_RISE: trig=0; wcnt +1 per cycle.
  - On an echo_s rising edge, go to MEASURE with wcnt=1 (the edge cycle counts).
  - If wcnt reaches ECHO_TIMEOUT first, pulse timeout and go to HOLDOFF; echo_width is unchanged.
  - echo_s already high on entry is not a rise; a low-then-high transition is required.
- MEASURE: wcnt +1 per cycle while echo_s=1.
  - On the echo_s falling edge: echo_width<=wcnt and width_valid=1 on the next cycle; detect=1 in the same cycle if wcnt < THRESH_CYCLES. Then go to HOLDOFF.
  - If wcnt reaches ECHO_TIMEOUT while echo_s is still high: echo_width<=ECHO_TIMEOUT, width_valid=1, timeout=1, detect=0, go to HOLDOFF.
- Latency: echo high for N clk cycles gives echo_width=N exactly. detect/width_valid appear 3 clk edges after the first clk edge that samples echo low.
- HOLDOFF: wait until pcnt == PERIOD_CYCLES-1 AND echo_s == 0. Then go to TRIG if enable=1, else IDLE. A stuck-high echo therefore delays the next trigger until echo releases.
- Dropping enable mid-measurement does not abort; the current cycle completes and its pulses are emitted.
- Width boundaries:
  - wcnt == THRESH_CYCLES: no detect (strict less-than).
  - wcnt == THRESH_CYCLES-1: detect.
- Pulse rules: detect, width_valid and timeout are each high for exactly one cycle per event. At most one echo_width update per period.
- Counter arithmetic is unsigned CW bits; no counter ever wraps.

Test Plan:
Use TRIG_CYCLES=10, PERIOD_CYCLES=1000, ECHO_TIMEOUT=400, THRESH_CYCLES=100 for all scenarios.
1. Release reset with enable=1 -> trig high exactly 10 cycles starting 1 cycle after IDLE. The next trig rise is exactly 1000 cycles after the first, with echo held low throughout.
2. Echo high for 60 cycles, starting 20 cycles after trig falls -> echo_width=60, width_valid and detect each pulse once, timeout=0.
3. Echo high for exactly 100 cycles -> echo_width=100, width_valid pulses, detect stays 0. Repeat with 99 cycles -> detect pulses.
4. No echo -> timeout pulses 400 cycles after trig falls, echo_width keeps its prior value, and the next trig still starts at period 1000. Echo stuck high -> echo_width=400 plus timeout; the next trig is delayed until echo drops after pcnt=999.
5. Echo high at the moment trig falls, then low 5 cycles, then high 30 cycles -> echo_width=30; the stale high is ignored.
6. Deassert enable during MEASURE -> the measurement completes with its pulses, then IDLE with busy=0. Assert reset mid-TRIG -> trig=0 asynchronously, all outputs 0, no pulses emitted.

Source files
------------

// File: rtl/ultrasonic_detect_if.sv
// Signal bundle between the ultrasonic ranger front-end and its controller.
// The slave modport is the detector; the master modport drives enable and echo.
interface ultrasonic_detect_if #(
    parameter int CW = 22
) ();
    logic          enable;
    logic          echo;
    logic          trig;
    logic          detect;
    logic [CW-1:0] echo_width;
    logic          width_valid;
    logic          timeout;
    logic          busy;

    modport master (
        output enable, echo,
        input  trig, detect, echo_width, width_valid, timeout, busy
    );

    modport slave (
        input  enable, echo,
        output trig, detect, echo_width, width_valid, timeout, busy
    );
endinterface

// File: rtl/ultrasonic_detect.sv
// Periodic HC-SR04 style ranger: fires trig, times the echo pulse and emits a
// one-cycle detect pulse when the echo is shorter than the distance threshold.
module ultrasonic_detect #(
    parameter int TRIG_CYCLES   = 500,
    parameter int PERIOD_CYCLES = 3000000,
    parameter int ECHO_TIMEOUT  = 1900000,
    parameter int THRESH_CYCLES = 145000,
    parameter int CW            = 22
) (
    input  logic               clk,
    input  logic               reset,
    ultrasonic_detect_if.slave bus
);

    localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
    localparam logic [CW-1:0] PER_LAST  = CW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] TMO       = CW'(ECHO_TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST  = CW'(ECHO_TIMEOUT - 1);
    localparam logic [CW-1:0] THRESH    = CW'(THRESH_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] echo_width_q, echo_width_d;
    logic          echo_meta_q, echo_meta_d;
    logic          echo_s_q, echo_s_d;
    logic          echo_dly_q, echo_dly_d;
    logic          detect_q, detect_d;
    logic          width_valid_q, width_valid_d;
    logic          timeout_q, timeout_d;
    logic          echo_rise;
    logic          echo_fall;

    assign echo_rise = echo_s_q & ~echo_dly_q;
    assign echo_fall = ~echo_s_q & echo_dly_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pcnt_q        <= '0;
            wcnt_q        <= '0;
            echo_width_q  <= '0;
            echo_meta_q   <= 1'b0;
            echo_s_q      <= 1'b0;
            echo_dly_q    <= 1'b0;
            detect_q      <= 1'b0;
            width_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pcnt_q        <= pcnt_d;
            wcnt_q        <= wcnt_d;
            echo_width_q  <= echo_width_d;
            echo_meta_q   <= echo_meta_d;
            echo_s_q      <= echo_s_d;
            echo_dly_q    <= echo_dly_d;
            detect_q      <= detect_d;
            width_valid_q <= width_valid_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pcnt_d        = (pcnt_q == PER_LAST) ? pcnt_q : pcnt_q + 1'b1;
        wcnt_d        = wcnt_q;
        echo_width_d  = echo_width_q;
        echo_meta_d   = bus.echo;
        echo_s_d      = echo_meta_q;
        echo_dly_d    = echo_s_q;
        detect_d      = 1'b0;
        width_valid_d = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d = S_TRIG;
                    pcnt_d  = '0;
                    wcnt_d  = '0;
                end
            end
            S_TRIG: begin
                if (wcnt_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_WAIT_RISE: begin
                // Only a low-to-high transition starts a measurement; a level left high from before is ignored.
                if (echo_rise) begin
                    state_d = S_MEASURE;
                    wcnt_d  = CW'(1);
                end else if (wcnt_q == TMO_LAST) begin
                    state_d   = S_HOLDOFF;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_MEASURE: begin
                if (echo_fall) begin
                    state_d       = S_HOLDOFF;
                    echo_width_d  = wcnt_q;
                    width_valid_d = 1'b1;
                    detect_d      = (wcnt_q < THRESH);
                end else if (wcnt_q == TMO) begin
                    state_d       = S_HOLDOFF;
                    echo_width_d  = TMO;
                    width_valid_d = 1'b1;
                    timeout_d     = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_HOLDOFF: begin
                // A stuck-high echo holds off the next trigger until the sensor releases it.
                if ((pcnt_q == PER_LAST) && !echo_s_q) begin
                    if (bus.enable) begin
                        state_d = S_TRIG;
                        pcnt_d  = '0;
                        wcnt_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.trig        = (state_q == S_TRIG);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.detect      = detect_q;
    assign bus.echo_width  = echo_width_q;
    assign bus.width_valid = width_valid_q;
    assign bus.timeout     = timeout_q;

endmodule
